fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter sharing the write port of one async_fifo (wclk side) between NREQ producer streams.
- Grants one requester at a time for a burst of up to BURST_LEN words, or until that requester flags its last word.
- Drives registered winc/wdata into the FIFO and throttles on wfull/awfull so the FIFO never overflows.
- Sits in the HOG pipeline between the per-stream feature producers and the clock-crossing FIFO.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DSIZE, 8, data width; must match the FIFO DSIZE.
- BURST_LEN, 4, maximum words per grant (1..255).

Ports:
- clk  in  1  write-domain clock, the same net as the FIFO wclk.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  NREQ  per-requester word valid.
- in_data  in  NREQ*DSIZE  packed data; requester i occupies bits [i*DSIZE +: DSIZE].
- in_last  in  NREQ  per-requester end-of-packet, qualified by valid.
- in_ready  out  NREQ  per-requester accept, combinational.
- winc  out  1  FIFO write enable, registered.
- wdata  out  DSIZE  FIFO write data, registered.
- wfull  in  1  FIFO full.
- awfull  in  1  FIFO almost full; asserted when at most one free slot remains.
- grant  out  NREQ  one-hot current owner, registered; zero when idle.
- busy  out  1  high while in BURST.

Behaviour:
- Reset, when rst_n is low at a clk edge: winc=0, wdata=0, grant=0, busy=0, state=IDLE, rr_ptr=0, beat_cnt=0. Reset asserted mid-burst abandons the burst; no partial state is kept.
- space_ok = !wfull && !(awfull && winc).
- States:
  - IDLE: if any in_valid is high, select the first valid index scanning upward from rr_ptr (wrapping). Load grant with that index one-hot, set beat_cnt=0, go to BURST. No data is accepted in IDLE. in_ready=0.
  - BURST: in_ready[g] = space_ok for the granted index g; all other bits are 0.
- Accept: an accept occurs when in_valid[g] && in_ready[g]. On the next edge: winc=1 and wdata=in_data[g]. With no accept, winc=0 on the next edge and wdata holds its value.
- Burst end: on an accept where in_last[g]=1 or beat_cnt==BURST_LEN-1, the next state is IDLE, grant=0, rr_ptr=(g+1) mod NREQ. Otherwise beat_cnt increments.
- Idle owner: if in_valid[g] drops during BURST, the grant is held and the arbiter waits. There is no timeout; producers guarantee completion.
- Latency: IDLE to first accept takes 1 cycle. Accept to winc takes 1 cycle. Peak rate is one word per clock.
- Fairness: after a burst by g, every other valid requester is granted before g again.
- Simultaneous in_last and the BURST_LEN limit: a single burst end, no double advance.
- wfull=1: no accepts, winc=0 from the next cycle; the grant is held.
- awfull=1 with winc=1: stall one cycle. awfull=1 with winc=0: one accept is allowed.
- beat_cnt width is clog2(BURST_LEN+1). rr_ptr width is clog2(NREQ).

Decomposition:
- Shared package hog_fifo_pkg:
  - state enum ST_IDLE/ST_BURST.
  - localparams for default DSIZE/ASIZE.
  - function clog2.
- Sub-module rr_pick:
  - Combinational round-robin priority picker.
  - Inputs: req[NREQ], ptr. Outputs: onehot, idx, any.
  - Instantiated once.

Test Plan:
- Single requester: NREQ=4, only in_valid[2]=1, data 0x10..0x17, in_last never set, BURST_LEN=4, FIFO empty -> grant=0100; winc high 4 consecutive cycles with 0x10..0x13; IDLE for 1 cycle; regrant to 2; 0x14..0x17 follow.
- Round-robin: all four valid continuously, 8 words each -> bursts granted in order 0,1,2,3,0,1,2,3; each burst is exactly 4 writes; no requester is granted twice in a row.
- in_last: req1 sends 0xA0, 0xA1 with in_last on 0xA1 while req3 is valid -> grant returns to IDLE after 2 writes; next grant is req3.
- Backpressure: hold wfull=1 for 5 cycles mid-burst -> in_ready=0, winc=0 throughout; grant unchanged; burst resumes after wfull=0 with no word lost or duplicated.
- awfull: awfull=1, wfull=0, continuous valid -> writes alternate winc 1,0,1,0; the FIFO model never overflows (ASIZE=3, depth 8).
- Reset mid-burst: drive rst_n=0 for one clk after the 2nd beat -> next cycle winc=0, grant=0, busy=0; after release, arbitration restarts from index 0.

Source files
------------

// File: rtl/hog_fifo_pkg.sv
// Shared types and helpers for the HOG write-side FIFO arbitration logic.
package hog_fifo_pkg;

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  localparam int unsigned DEF_DSIZE = 8;
  localparam int unsigned DEF_ASIZE = 3;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int unsigned j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = (32'(ptr) + i) % NREQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        idx       = PW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async FIFO write port among NREQ producers.
module fifo_wr_arbiter
  import hog_fifo_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DSIZE     = DEF_DSIZE,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       in_valid,
  input  logic [NREQ*DSIZE-1:0] in_data,
  input  logic [NREQ-1:0]       in_last,
  output logic [NREQ-1:0]       in_ready,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  input  logic                  wfull,
  input  logic                  awfull,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);

  localparam int unsigned PW = clog2(NREQ);
  localparam int unsigned BW = clog2(BURST_LEN + 1);

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gidx;
  logic [BW-1:0]   beat_cnt;

  logic [NREQ-1:0] pick_onehot;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;

  logic            space_ok;
  logic            accept;
  logic            burst_end;
  logic [DSIZE-1:0] sel_data;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (in_valid),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // A write already in flight consumes the last slot flagged by awfull.
  assign space_ok  = !wfull && !(awfull && winc);
  assign in_ready  = (state == ST_BURST && space_ok) ? grant : '0;
  assign accept    = |(in_valid & in_ready);
  assign sel_data  = in_data[gidx*DSIZE +: DSIZE];
  assign burst_end = in_last[gidx] || (beat_cnt == BW'(BURST_LEN - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      winc     <= 1'b0;
      wdata    <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      rr_ptr   <= '0;
      gidx     <= '0;
      beat_cnt <= '0;
    end else begin
      winc <= accept;
      if (accept) wdata <= sel_data;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant    <= pick_onehot;
            gidx     <= pick_idx;
            beat_cnt <= '0;
            busy     <= 1'b1;
            state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (accept) begin
            if (burst_end) begin
              grant  <= '0;
              busy   <= 1'b0;
              state  <= ST_IDLE;
              rr_ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table plus scoreboarded multi-cycle scenarios.
module tb_fifo_wr_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DSIZE = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NREQ-1:0]  in_valid = '0;
  logic [NREQ*DSIZE-1:0] in_data = '0;
  logic [NREQ-1:0]  in_last = '0;
  logic [NREQ-1:0]  in_ready;
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             wfull = 1'b0;
  logic             awfull = 1'b0;
  logic [NREQ-1:0]  grant;
  logic             busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .winc(winc), .wdata(wdata),
    .wfull(wfull), .awfull(awfull), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } word_t;

  typedef struct {
    logic [3:0] valid;
    logic       wf;
    logic       af;
    logic [3:0] exp_grant;
    logic       exp_busy;
    logic [3:0] exp_ready;
  } vec_t;

  word_t      src [NREQ][$];
  logic [7:0] exp_q[$];
  logic [3:0] owner_log[$];
  logic [3:0] prev_grant = '0;
  logic       obs_winc;
  logic [3:0] obs_ready;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_inputs();
    in_valid = '0;
    in_last  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (src[i].size() > 0) begin
        in_valid[i] = 1'b1;
        in_data[i*DSIZE +: DSIZE] = src[i][0].d;
        in_last[i] = src[i][0].l;
      end
    end
  endtask

  task automatic step();
    logic [3:0] acc;
    logic [7:0] e;
    @(negedge clk);
    drive_inputs();
    #1;
    obs_ready = in_ready;
    acc = in_valid & in_ready & {NREQ{rst_n}};
    @(posedge clk);
    for (int i = 0; i < NREQ; i++)
      if (acc[i]) void'(src[i].pop_front());
    #1;
    obs_winc = winc;
    if (winc) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got %0h expected none", wdata);
      end else begin
        e = exp_q.pop_front();
        check("wdata", 32'(wdata), 32'(e));
      end
    end
    if (prev_grant == '0 && grant != '0) owner_log.push_back(grant);
    prev_grant = grant;
  endtask

  task automatic run_done(input string name, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load(input int r, input logic [7:0] d, input logic l);
    word_t w;
    w.d = d;
    w.l = l;
    src[r].push_back(w);
    exp_q.push_back(d);
  endtask

  task automatic do_reset(input logic chk);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) src[i].delete();
    exp_q.delete();
    owner_log.delete();
    in_valid = '0;
    in_last = '0;
    wfull = 1'b0;
    awfull = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    if (chk) begin
      check("rst_winc", 32'(winc), 32'd0);
      check("rst_wdata", 32'(wdata), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prev_grant = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    bit   w_pat[11];
    logic [3:0] eo;

    vecs[0] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000};
    vecs[1] = '{4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100};
    vecs[2] = '{4'b1010, 1'b0, 1'b0, 4'b0010, 1'b1, 4'b0010};
    vecs[3] = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001};
    vecs[4] = '{4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b0000};
    vecs[5] = '{4'b1001, 1'b0, 1'b1, 4'b0001, 1'b1, 4'b0001};
    w_pat = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    do_reset(1'b1);

    // Vector table: first grant from pointer 0 and the resulting in_ready.
    for (int v = 0; v < 6; v++) begin
      do_reset(1'b0);
      @(negedge clk);
      in_valid = vecs[v].valid;
      in_last  = '1;
      wfull    = vecs[v].wf;
      awfull   = vecs[v].af;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_grant", v), 32'(grant), 32'(vecs[v].exp_grant));
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_ready", v), 32'(in_ready), 32'(vecs[v].exp_ready));
    end

    // Single requester, burst limit 4 with one idle cycle between bursts.
    do_reset(1'b0);
    for (int k = 0; k < 8; k++) load(2, 8'(8'h10 + k), 1'b0);
    for (int s = 0; s < 11; s++) begin
      step();
      check($sformatf("t1_winc%0d", s), 32'(obs_winc), 32'(w_pat[s]));
      if (s == 0 || s == 5) check("t1_grant", 32'(grant), 32'b0100);
      if (s == 4) check("t1_idle_grant", 32'(grant), 32'd0);
    end
    check("t1_drain", 32'(exp_q.size()), 32'd0);

    // Round-robin with all requesters continuously valid.
    do_reset(1'b0);
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++) load(r, 8'(r * 16 + b * 4 + k), 1'b0);
    run_done("t2", 200);
    check("t2_nbursts", 32'(owner_log.size()), 32'd8);
    for (int n = 0; n < owner_log.size(); n++) begin
      eo = 4'b0001 << (n % 4);
      check($sformatf("t2_owner%0d", n), 32'(owner_log[n]), 32'(eo));
    end

    // in_last ends a burst early; req3 follows.
    do_reset(1'b0);
    load(1, 8'hA0, 1'b0);
    load(1, 8'hA1, 1'b1);
    load(3, 8'hB0, 1'b0);
    load(3, 8'hB1, 1'b1);
    run_done("t3", 50);
    check("t3_nbursts", 32'(owner_log.size()), 32'd2);
    if (owner_log.size() >= 2) begin
      check("t3_owner0", 32'(owner_log[0]), 32'b0010);
      check("t3_owner1", 32'(owner_log[1]), 32'b1000);
    end

    // wfull held mid-burst: nothing accepted, grant held, no word lost.
    do_reset(1'b0);
    for (int k = 0; k < 8; k++) load(0, 8'(8'h40 + k), 1'b0);
    repeat (3) step();
    wfull = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      check("t4_ready", 32'(obs_ready), 32'd0);
      check("t4_winc", 32'(obs_winc), 32'd0);
      check("t4_grant", 32'(grant), 32'b0001);
    end
    wfull = 1'b0;
    run_done("t4", 50);

    // awfull held: one write, one stall, alternating.
    do_reset(1'b0);
    awfull = 1'b1;
    for (int k = 0; k < 8; k++) load(0, 8'(8'h50 + k), 1'b0);
    step();
    for (int s = 0; s < 8; s++) begin
      step();
      check($sformatf("t5_winc%0d", s), 32'(obs_winc), (s % 2 == 0) ? 32'd1 : 32'd0);
    end
    run_done("t5", 50);
    awfull = 1'b0;

    // Reset after the second beat abandons the burst; arbitration restarts at index 0.
    do_reset(1'b0);
    for (int k = 0; k < 2; k++) load(3, 8'(8'h60 + k), 1'b0);
    step();
    check("t6_grant", 32'(grant), 32'b1000);
    step();
    step();
    rst_n = 1'b0;
    load(0, 8'h70, 1'b0);
    load(0, 8'h71, 1'b1);
    for (int k = 2; k < 8; k++) load(3, 8'(8'h60 + k), 1'b0);
    step();
    check("t6_rst_winc", 32'(obs_winc), 32'd0);
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();
    check("t6_regrant", 32'(grant), 32'b0001);
    run_done("t6", 60);
    check("t6_nbursts", 32'(owner_log.size()), 32'd4);
    if (owner_log.size() >= 3) check("t6_after_req0", 32'(owner_log[2]), 32'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
